dmem_responder: RTL

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/gpu_pkg.sv | 14 +
 rtl/dmem_responder_rsp_fifo.sv | 51 +++++
 rtl/dmem_responder.sv | 93 +++++++++
 3 files changed

// File: rtl/gpu_pkg.sv
// Shared types and sizing for the data-memory responder and its response queue.
package gpu_pkg;
   localparam int DMEM_DEPTH     = 256;
   localparam int RSP_FIFO_DEPTH = 4;
   localparam int LANE_W         = 4;
   localparam int DATA_W         = 16;
   localparam int ADDR_W         = 16;

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic [LANE_W-1:0] lane;
      logic              err;
   } dmem_rsp_t;
endpackage

// File: rtl/dmem_responder_rsp_fifo.sv
// Response queue: circular buffer of dmem_rsp_t entries, head shown combinationally.
module rsp_fifo
   import gpu_pkg::*;
#(
   parameter int DEPTH = RSP_FIFO_DEPTH,
   localparam int PW   = $clog2(DEPTH),
   localparam int CW   = PW + 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_push,
   input  dmem_rsp_t     i_data,
   input  logic          i_pop,
   output dmem_rsp_t     o_head,
   output logic [CW-1:0] o_count
);

   dmem_rsp_t     r_mem [DEPTH];
   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;
   logic          w_pop;

   assign w_pop = i_pop && (r_count != '0);

   // Pointers are exactly log2(DEPTH) wide, so they wrap modulo DEPTH for free.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (i_push) r_wr_ptr <= r_wr_ptr + PW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
         case ({i_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (i_push) r_mem[r_wr_ptr] <= i_data;
   end

   // Storage is not reset; masking the head keeps the outputs at zero when empty.
   assign o_head  = (r_count != '0) ? r_mem[r_rd_ptr] : '0;
   assign o_count = r_count;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: single-port word RAM, one load stage, in-order response queue.
module dmem_responder
   import gpu_pkg::*;
#(
   parameter int DEPTH     = DMEM_DEPTH,
   parameter int RSP_DEPTH = RSP_FIFO_DEPTH
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   input  logic [LANE_W-1:0] req_lane,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_data,
   output logic [LANE_W-1:0] rsp_lane,
   output logic              rsp_err,
   output logic              busy
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(RSP_DEPTH) + 1;

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [DATA_W-1:0] r_s1_data;
   logic [LANE_W-1:0] r_s1_lane;
   logic              r_s1_err;
   logic              r_s1_valid;

   logic              w_accept;
   logic              w_in_range;
   logic [31:0]       w_addr_ext;
   logic [AW-1:0]     w_idx;
   logic [CW-1:0]     w_fifo_count;
   dmem_rsp_t         w_push_rsp;
   dmem_rsp_t         w_head;

   assign w_accept   = req_valid && req_ready;
   assign w_addr_ext = {16'd0, req_addr};
   assign w_in_range = w_addr_ext < 32'(DEPTH);
   assign w_idx      = req_addr[AW-1:0];

   // One access per cycle and no reset, so this maps onto a single-port sync RAM.
   always_ff @(posedge clk) begin
      if (w_accept && w_in_range) begin
         if (req_write) r_mem[w_idx] <= req_wdata;
         else           r_s1_data    <= r_mem[w_idx];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_s1_valid <= 1'b0;
         r_s1_lane  <= '0;
         r_s1_err   <= 1'b0;
      end else begin
         r_s1_valid <= w_accept && !req_write;
         if (w_accept && !req_write) begin
            r_s1_lane <= req_lane;
            r_s1_err  <= !w_in_range;
         end
      end
   end

   // Out-of-range loads never read the RAM, so their stale data is replaced by zero.
   always_comb begin
      w_push_rsp      = '0;
      w_push_rsp.data = r_s1_err ? '0 : r_s1_data;
      w_push_rsp.lane = r_s1_lane;
      w_push_rsp.err  = r_s1_err;
   end

   rsp_fifo #(.DEPTH(RSP_DEPTH)) u_rsp_fifo (
      .clk     (clk),
      .rst_n   (reset),
      .i_push  (r_s1_valid),
      .i_data  (w_push_rsp),
      .i_pop   (rsp_ready),
      .o_head  (w_head),
      .o_count (w_fifo_count)
   );

   assign req_ready = (32'(w_fifo_count) + 32'(r_s1_valid)) < 32'(RSP_DEPTH);
   assign rsp_valid = w_fifo_count != '0;
   assign rsp_data  = w_head.data;
   assign rsp_lane  = w_head.lane;
   assign rsp_err   = w_head.err;
   assign busy      = r_s1_valid || (w_fifo_count != '0);

endmodule
